// File: rtl/bus_width_increase_if.sv
// Narrow-beat input stream and wide-word output stream of bus_width_increase.
// The DUT connects through the slave modport. A bench or upstream logic drives the master modport.
interface bus_width_increase_if #(
   parameter int unsigned SIZE_IN  = 8,
   parameter int unsigned SIZE_OUT = 32
);
   localparam int unsigned RATIO = SIZE_OUT / SIZE_IN;

   logic                input_valid;
   logic                input_ready;
   logic [SIZE_IN-1:0]  data_in;
   logic                input_last;
   logic                output_valid;
   logic                output_ready;
   logic [SIZE_OUT-1:0] data_out;
   logic [RATIO-1:0]    output_keep;
   logic                output_last;

   modport slave (
      input  input_valid, data_in, input_last, output_ready,
      output input_ready, output_valid, data_out, output_keep, output_last
   );

   modport master (
      output input_valid, data_in, input_last, output_ready,
      input  input_ready, output_valid, data_out, output_keep, output_last
   );
endinterface

// File: rtl/bus_width_increase.sv
// Packs SIZE_IN-bit beats little-endian into SIZE_OUT-bit words.
// A word may end early on input_last; its keep mask then marks only the lanes that were written.
module bus_width_increase #(
   parameter int unsigned SIZE_IN  = 8,
   parameter int unsigned SIZE_OUT = 32
) (
   input logic                 clk,
   input logic                 reset,
   bus_width_increase_if.slave bus
);
   localparam int unsigned RATIO = SIZE_OUT / SIZE_IN;
   localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0]    cnt;
   logic [SIZE_OUT-1:0] acc_data;
   logic [RATIO-1:0]    acc_keep;
   logic                acc_last;
   logic                acc_full;

   logic [SIZE_OUT-1:0] out_data;
   logic [RATIO-1:0]    out_keep;
   logic                out_last;
   logic                out_valid;

   logic [SIZE_OUT-1:0] wr_data;
   logic [RATIO-1:0]    wr_keep;
   logic                beat;
   logic                complete;
   logic                slot_free;
   logic                in_ready;

   assign in_ready  = !acc_full && !reset;
   assign beat      = bus.input_valid && in_ready;
   assign complete  = beat && ((cnt == LAST_LANE) || bus.input_last);
   assign slot_free = !out_valid || bus.output_ready;

   // Word as it would look with the current beat merged into lane cnt.
   always_comb begin
      wr_data = acc_data;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (cnt == CNT_W'(k)) begin
            wr_data[k*SIZE_IN +: SIZE_IN] = bus.data_in;
         end
      end
      wr_keep = acc_keep | (RATIO'(1) << cnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         acc_data  <= '0;
         acc_keep  <= '0;
         acc_last  <= 1'b0;
         acc_full  <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && bus.output_ready) begin
            out_valid <= 1'b0;
         end

         // A held word always drains first. Beats are blocked while acc_full is set, so both cannot happen in one cycle.
         if (acc_full) begin
            if (slot_free) begin
               out_data  <= acc_data;
               out_keep  <= acc_keep;
               out_last  <= acc_last;
               out_valid <= 1'b1;
               acc_data  <= '0;
               acc_keep  <= '0;
               acc_last  <= 1'b0;
               acc_full  <= 1'b0;
            end
         end else if (complete) begin
            cnt <= '0;
            if (slot_free) begin
               out_data  <= wr_data;
               out_keep  <= wr_keep;
               out_last  <= bus.input_last;
               out_valid <= 1'b1;
               acc_data  <= '0;
               acc_keep  <= '0;
               acc_last  <= 1'b0;
            end else begin
               acc_data  <= wr_data;
               acc_keep  <= wr_keep;
               acc_last  <= bus.input_last;
               acc_full  <= 1'b1;
            end
         end else if (beat) begin
            acc_data <= wr_data;
            acc_keep <= wr_keep;
            cnt      <= cnt + 1'b1;
         end
      end
   end

   assign bus.input_ready  = in_ready;
   assign bus.output_valid = out_valid;
   assign bus.data_out     = out_data;
   assign bus.output_keep  = out_keep;
   assign bus.output_last  = out_last;
endmodule

// File: tb/tb_bus_width_increase.sv
// Self-checking bench for bus_width_increase with 8-bit beats and 32-bit words.
module tb_bus_width_increase;
   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;

   bus_width_increase_if #(.SIZE_IN(8), .SIZE_OUT(32)) bus ();

   bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        l;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        el;
   } vec_t;

   vec_t vecs [15];

   logic [31:0] sb_d [$];
   logic [3:0]  sb_k [$];
   logic        sb_l [$];
   logic [31:0] m_w;
   logic [3:0]  m_k;
   int          m_lane;
   int          sent, words, stalls;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.input_valid  = 1'b0;
      bus.input_last   = 1'b0;
      bus.output_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic sb_reset();
      sb_d.delete();
      sb_k.delete();
      sb_l.delete();
      m_w = '0;
      m_k = '0;
      m_lane = 0;
      sent = 0;
      words = 0;
      stalls = 0;
   endtask

   task automatic model_beat(input logic [7:0] d, input logic l);
      m_w[8*m_lane +: 8] = d;
      m_k[m_lane] = 1'b1;
      if (m_lane == 3 || l) begin
         sb_d.push_back(m_w);
         sb_k.push_back(m_k);
         sb_l.push_back(l);
         m_w = '0;
         m_k = '0;
         m_lane = 0;
      end else begin
         m_lane++;
      end
   endtask

   task automatic observe_word();
      if (sb_d.size() == 0) begin
         chk("word_unexpected", bus.output_valid, 1'b0);
      end else begin
         chk("sb_data", bus.data_out, sb_d.pop_front());
         chk("sb_keep", bus.output_keep, sb_k.pop_front());
         chk("sb_last", bus.output_last, sb_l.pop_front());
      end
      words++;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, bus.output_valid, 1'b0);
      chk({tag, "_data"},  bus.data_out, 32'h0);
      chk({tag, "_keep"},  bus.output_keep, 4'h0);
      chk({tag, "_last"},  bus.output_last, 1'b0);
      chk({tag, "_ready"}, bus.input_ready, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'h11, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[1]  = '{8'h22, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[2]  = '{8'h33, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[3]  = '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
      vecs[4]  = '{8'hAA, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[5]  = '{8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
      vecs[6]  = '{8'h01, 1'b1, 1'b1, 32'h00000001, 4'h1, 1'b1};
      vecs[7]  = '{8'h55, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[8]  = '{8'h66, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[9]  = '{8'h77, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[10] = '{8'h88, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b1};
      vecs[11] = '{8'h99, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[12] = '{8'hAB, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[13] = '{8'hCD, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
      vecs[14] = '{8'hEF, 1'b0, 1'b1, 32'hEFCDAB99, 4'hF, 1'b0};

      reset = 1'b1;
      bus.input_valid  = 1'b0;
      bus.input_last   = 1'b0;
      bus.data_in      = '0;
      bus.output_ready = 1'b0;
      tick();
      tick();
      check_zero_outputs("reset");
      reset = 1'b0;
      #1;
      chk("ready_after_reset", bus.input_ready, 1'b1);

      // Table-driven packing with output_ready held high.
      bus.output_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         bus.input_valid = 1'b1;
         bus.data_in     = vecs[i].d;
         bus.input_last  = vecs[i].l;
         #1;
         chk($sformatf("vec%0d_ready", i), bus.input_ready, 1'b1);
         tick();
         chk($sformatf("vec%0d_valid", i), bus.output_valid, vecs[i].ev);
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].ed);
            chk($sformatf("vec%0d_keep", i), bus.output_keep, vecs[i].ek);
            chk($sformatf("vec%0d_last", i), bus.output_last, vecs[i].el);
         end
      end
      idle();

      // Back-pressure: two words held, ready drops, then drains in order.
      bus.output_ready = 1'b0;
      bus.input_valid  = 1'b1;
      bus.input_last   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.data_in = 8'(i + 1);
         #1;
         chk($sformatf("bp_ready%0d", i), bus.input_ready, 1'b1);
         tick();
      end
      bus.data_in = 8'h09;
      chk("bp_ready_low", bus.input_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", bus.output_valid, 1'b1);
         chk("bp_hold_data", bus.data_out, 32'h04030201);
         chk("bp_hold_ready", bus.input_ready, 1'b0);
         tick();
      end
      bus.output_ready = 1'b1;
      tick();
      chk("bp_second_valid", bus.output_valid, 1'b1);
      chk("bp_second_data", bus.data_out, 32'h08070605);
      chk("bp_ready_back", bus.input_ready, 1'b1);
      tick();
      chk("bp_drained", bus.output_valid, 1'b0);
      bus.data_in    = 8'h0A;
      bus.input_last = 1'b1;
      tick();
      chk("bp_ninth_valid", bus.output_valid, 1'b1);
      chk("bp_ninth_data", bus.data_out, 32'h00000A09);
      chk("bp_ninth_keep", bus.output_keep, 4'h3);
      idle();

      // Reset mid-word discards the partial word.
      bus.input_valid = 1'b1;
      bus.input_last  = 1'b0;
      bus.data_in = 8'h12;
      tick();
      bus.data_in = 8'h34;
      tick();
      bus.input_valid = 1'b0;
      reset = 1'b1;
      tick();
      check_zero_outputs("midreset");
      reset = 1'b0;
      sb_reset();
      for (int i = 0; i < 4; i++) model_beat(8'(32'hEFBEADDE >> (8 * i)), 1'b0);
      for (int cyc = 0; cyc < 12; cyc++) begin
         bus.input_valid = (cyc < 4);
         bus.data_in     = 8'(32'hEFBEADDE >> (8 * cyc));
         #1;
         if (bus.output_valid && bus.output_ready) observe_word();
         tick();
      end
      chk("midreset_words", words, 1);
      idle();

      // 100 random bytes with output_ready high.
      sb_reset();
      bus.output_ready = 1'b1;
      bus.input_last   = 1'b0;
      for (int cyc = 0; cyc < 300 && (sent < 100 || sb_d.size() > 0); cyc++) begin
         bus.input_valid = (sent < 100);
         bus.data_in     = 8'($urandom_range(0, 255));
         #1;
         if (bus.input_valid && !bus.input_ready) stalls++;
         if (bus.output_valid && bus.output_ready) observe_word();
         if (bus.input_valid && bus.input_ready) begin
            model_beat(bus.data_in, 1'b0);
            sent++;
         end
         tick();
      end
      chk("stream_sent", sent, 100);
      chk("stream_words", words, 25);
      chk("stream_stalls", stalls, 0);
      chk("stream_leftover", sb_d.size(), 0);
      idle();

      // Sparse output_ready plus random input_last.
      sb_reset();
      for (int cyc = 0; cyc < 3000 && (sent < 100 || sb_d.size() > 0); cyc++) begin
         bus.output_ready = (cyc % 5 == 0);
         bus.input_valid  = (sent < 100);
         bus.data_in      = 8'($urandom_range(0, 255));
         bus.input_last   = ($urandom_range(0, 3) == 0);
         #1;
         if (bus.output_valid && bus.output_ready) observe_word();
         if (bus.input_valid && bus.input_ready) begin
            model_beat(bus.data_in, bus.input_last);
            sent++;
         end
         tick();
      end
      chk("sparse_sent", sent, 100);
      chk("sparse_leftover", sb_d.size(), 0);
      chk("sparse_partial", m_lane, 0);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
